// File: rtl/cmn_sram_1r1w_pipelined.sv
// Simple-dual-port SRAM: lane-masked writes, pipelined reads,
// optional zeroing sweep after reset before the ports open.
module cmn_sram_1r1w_pipelined #(
  parameter int p_data_nbits     = 32,
  parameter int p_num_entries    = 64,
  parameter int p_lane_nbits     = 8,
  parameter int p_read_latency   = 1,
  parameter int p_collision_mode = 0,
  parameter int p_init_clear     = 1,
  localparam int c_addr_nbits =
    (p_num_entries > 1) ? $clog2(p_num_entries) : 1,
  localparam int c_num_lanes =
    (p_data_nbits + p_lane_nbits - 1) / p_lane_nbits
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    init_done,
  input  logic                    read_en,
  input  logic [c_addr_nbits-1:0] read_addr,
  output logic [p_data_nbits-1:0] read_data,
  output logic                    read_valid,
  input  logic                    write_en,
  input  logic [c_num_lanes-1:0]  write_lane_en,
  input  logic [c_addr_nbits-1:0] write_addr,
  input  logic [p_data_nbits-1:0] write_data
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  localparam logic [c_addr_nbits:0] c_depth =
    (c_addr_nbits + 1)'(p_num_entries);
  localparam logic [c_addr_nbits-1:0] c_last =
    c_addr_nbits'(p_num_entries - 1);

  typedef logic [p_data_nbits-1:0] word_t;

  word_t mem [p_num_entries];

  logic [0:0]              state;
  logic [c_addr_nbits-1:0] clear_ptr;

  wire [p_data_nbits-1:0] mask;
  word_t                  rd_word;
  logic                   rd_in;
  logic                   wr_in;
  logic                   rd_acc;
  logic                   wr_acc;
  logic                   hit;

  logic [p_read_latency-1:0] vld;
  logic [p_read_latency:0]   vld_x;

  logic [p_read_latency-1:0][p_data_nbits-1:0] dat;
  logic [p_read_latency-1:0][p_data_nbits-1:0] dat_d;
  logic [p_read_latency:0][p_data_nbits-1:0]   dat_x;

  // Each data bit follows the enable of the lane it falls in.
  for (genvar b = 0; b < p_data_nbits; b++) begin : g_mask
    assign mask[b] = write_lane_en[b / p_lane_nbits];
  end

  assign rd_in  = {1'b0, read_addr} < c_depth;
  assign wr_in  = {1'b0, write_addr} < c_depth;
  assign rd_acc = init_done & read_en;
  assign wr_acc = init_done & write_en & wr_in;
  assign hit    = wr_acc & (read_addr == write_addr)
                & (p_collision_mode != 0);

  always_comb begin
    rd_word = '0;
    if (rd_in) begin
      rd_word = mem[read_addr];
      if (hit)
        rd_word = (mem[read_addr] & ~mask) | (write_data & mask);
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_CLEAR)
      mem[clear_ptr] <= '0;
    else if (wr_acc)
      mem[write_addr] <= (mem[write_addr] & ~mask)
                       | (write_data & mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= (p_init_clear != 0) ? S_CLEAR : S_READY;
      clear_ptr <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (1'b1)
        state == S_CLEAR: begin
          clear_ptr <= clear_ptr + c_addr_nbits'(1);
          if (clear_ptr == c_last) begin
            state     <= S_READY;
            init_done <= 1'b1;
          end
        end
        state == S_READY: init_done <= 1'b1;
      endcase
    end
  end

  assign vld_x = {vld, rd_acc};
  assign dat_x = {dat, rd_word};

  // Last stage only loads on a valid read so read_data holds otherwise.
  always_comb begin
    dat_d = dat_x[p_read_latency-1:0];
    if (!vld_x[p_read_latency-1])
      dat_d[p_read_latency-1] = dat[p_read_latency-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      dat <= '0;
    end else begin
      vld <= vld_x[p_read_latency-1:0];
      dat <= dat_d;
    end
  end

  assign read_valid = vld[p_read_latency-1];
  assign read_data  = dat[p_read_latency-1];

endmodule
